// File: rtl/mmio_interconnect.sv
// mmio_interconnect: memory-mapped I/O fabric between the CPU data port and
// NUM_SLAVES peripheral windows. Registered one-hot decode, per-slave ready
// handshake with wait states, and a timeout that turns a silent slave into a
// bus-error response. Unmapped addresses also answer with a bus error.
//
// Handshake: the master holds m_read_enable/m_write_enable until m_ready, which
// is a one-cycle pulse qualified by m_bus_error. Toward the slaves, s_select and
// the strobes are held for the whole access; slave i ends it with s_ready[i]=1.
// Master inputs are only sampled in IDLE.
module mmio_interconnect #(
  parameter int                    NUM_SLAVES     = 8,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS   = ADDR_WIDTH'(32'hFF20_0000),
  parameter int                    WINDOW_BITS    = 8,
  parameter int                    TIMEOUT_CYCLES = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             m_read_enable,
  input  logic                             m_write_enable,
  input  logic [DATA_WIDTH/8-1:0]          m_byte_enable,
  input  logic [ADDR_WIDTH-1:0]            m_address,
  input  logic [DATA_WIDTH-1:0]            m_write_data,
  output logic [DATA_WIDTH-1:0]            m_read_data,
  output logic                             m_ready,
  output logic                             m_bus_error,
  output logic [NUM_SLAVES-1:0]            s_select,
  output logic                             s_read_enable,
  output logic                             s_write_enable,
  output logic [DATA_WIDTH/8-1:0]          s_byte_enable,
  output logic [WINDOW_BITS-1:0]           s_address,
  output logic [DATA_WIDTH-1:0]            s_write_data,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_read_data,
  input  logic [NUM_SLAVES-1:0]            s_ready,
  output logic [15:0]                      error_count,
  output logic [1:0]                       dbg_state_o
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    ready_q, ready_d;
  logic                    berr_q, berr_d;
  logic [NUM_SLAVES-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;
  logic [BE_W-1:0]         be_q, be_d;
  logic [WINDOW_BITS-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [15:0]             ecnt_q, ecnt_d;

  // Address decode of the live master request (only consumed in IDLE).
  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH-1:0] idx_full;
  logic                  hit;
  always_comb begin
    off      = m_address - BASE_ADDRESS;
    idx_full = off >> WINDOW_BITS;
    hit      = (m_address >= BASE_ADDRESS) && (idx_full < ADDR_WIDTH'(NUM_SLAVES));
  end

  // Next-state and next-output logic; every branch into RESPOND loads the
  // response registers so m_ready/m_bus_error/m_read_data are registered.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    berr_d  = 1'b0;
    sel_d   = sel_q;
    idx_d   = idx_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    ecnt_d  = ecnt_q;
    case (state_q)
      IDLE: begin
        if (m_read_enable || m_write_enable) begin
          if (hit) begin
            state_d = ACCESS;
            idx_d   = idx_full[IDX_W-1:0];
            sel_d   = NUM_SLAVES'(1) << idx_full[IDX_W-1:0];
            // A simultaneous read is dropped: write wins.
            wr_d    = m_write_enable;
            rd_d    = m_read_enable && !m_write_enable;
            be_d    = m_byte_enable;
            addr_d  = off[WINDOW_BITS-1:0];
            wdata_d = m_write_data;
            cnt_d   = '0;
          end else begin
            state_d = RESPOND;
            ready_d = 1'b1;
            berr_d  = 1'b1;
            rdata_d = '1;
            if (ecnt_q != 16'hFFFF) ecnt_d = ecnt_q + 16'd1;
          end
        end
      end
      ACCESS: begin
        if (s_ready[idx_q]) begin
          state_d = RESPOND;
          ready_d = 1'b1;
          rdata_d = wr_q ? '0 : s_read_data[idx_q*DATA_WIDTH +: DATA_WIDTH];
          sel_d   = '0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          // The first ACCESS cycle plus TIMEOUT_CYCLES wait cycles have elapsed.
          state_d = RESPOND;
          ready_d = 1'b1;
          berr_d  = 1'b1;
          rdata_d = '1;
          sel_d   = '0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          if (ecnt_q != 16'hFFFF) ecnt_d = ecnt_q + 16'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rdata_q <= '0;
      ready_q <= 1'b0;
      berr_q  <= 1'b0;
      sel_q   <= '0;
      idx_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      berr_q  <= berr_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign m_read_data    = rdata_q;
  assign m_ready        = ready_q;
  assign m_bus_error    = berr_q;
  assign s_select       = sel_q;
  assign s_read_enable  = rd_q;
  assign s_write_enable = wr_q;
  assign s_byte_enable  = be_q;
  assign s_address      = addr_q;
  assign s_write_data   = wdata_q;
  assign error_count    = ecnt_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_mmio_interconnect.sv
// Bench for mmio_interconnect: a slave model with per-slave wait counts and
// random ready noise on unselected slaves, a master driver task, and a
// scoreboard of expected {bus_error, read_data} responses and latencies.
module tb_mmio_interconnect;

  localparam int          NS   = 8;
  localparam int          DW   = 32;
  localparam int          AW   = 32;
  localparam int          WB   = 8;
  localparam int          TO   = 16;
  localparam logic [31:0] BASE = 32'hFF20_0000;

  logic            clock = 1'b0;
  logic            reset;
  logic            m_read_enable, m_write_enable;
  logic [3:0]      m_byte_enable;
  logic [AW-1:0]   m_address;
  logic [DW-1:0]   m_write_data;
  logic [DW-1:0]   m_read_data;
  logic            m_ready, m_bus_error;
  logic [NS-1:0]   s_select;
  logic            s_read_enable, s_write_enable;
  logic [3:0]      s_byte_enable;
  logic [WB-1:0]   s_address;
  logic [DW-1:0]   s_write_data;
  logic [NS*DW-1:0] s_read_data;
  logic [NS-1:0]   s_ready;
  logic [15:0]     error_count;
  logic [1:0]      dbg_state;

  logic [DW-1:0]   slv_data [NS];
  int              wait_cfg [NS];
  int              acc_n;

  logic [DW:0]     exp_q[$];
  int              lat_q[$];
  logic [15:0]     exp_ecnt;
  int              n_checks;
  int              n_errors;

  mmio_interconnect #(
    .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDRESS(BASE),
    .WINDOW_BITS(WB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .m_read_enable(m_read_enable), .m_write_enable(m_write_enable),
    .m_byte_enable(m_byte_enable), .m_address(m_address), .m_write_data(m_write_data),
    .m_read_data(m_read_data), .m_ready(m_ready), .m_bus_error(m_bus_error),
    .s_select(s_select), .s_read_enable(s_read_enable), .s_write_enable(s_write_enable),
    .s_byte_enable(s_byte_enable), .s_address(s_address), .s_write_data(s_write_data),
    .s_read_data(s_read_data), .s_ready(s_ready), .error_count(error_count),
    .dbg_state_o(dbg_state)
  );

  // Clock
  always #5 clock = ~clock;

  // Slave read buses
  always_comb begin
    s_read_data = '0;
    for (int i = 0; i < NS; i++) s_read_data[i*DW +: DW] = slv_data[i];
  end

  // Slave model: selected slave answers after wait_cfg cycles; others toggle noise
  always @(posedge clock) begin
    logic [NS-1:0] noise;
    logic [NS-1:0] hitv;
    #1;
    noise = NS'($urandom_range(0, 255));
    hitv  = '0;
    if (s_select != '0) begin
      acc_n++;
      for (int i = 0; i < NS; i++)
        if (s_select[i] && acc_n == wait_cfg[i] + 1) hitv[i] = 1'b1;
    end else begin
      acc_n = 0;
    end
    s_ready = hitv | (noise & ~s_select);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One master transaction, with the expected response derived from the address map
  task automatic run_txn(input bit rd, input bit wr, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int wt, input string tag);
    logic [31:0] off;
    int          idx;
    bit          hit;
    bit          e_err;
    logic [31:0] e_data;
    int          e_lat;
    logic [DW:0] got;
    int          got_lat;
    int          n;
    int          strobes;
    logic [NS-1:0] sel_seen;
    bit          done;
    off   = addr - BASE;
    idx   = int'(off >> WB);
    hit   = (addr >= BASE) && ((off >> WB) < NS);
    e_err = 1'b0;
    if (!hit) begin
      e_err = 1'b1; e_data = '1; e_lat = 1;
    end else begin
      wait_cfg[idx] = wt;
      if (wt <= TO) begin
        e_lat  = wt + 2;
        e_data = wr ? 32'h0 : slv_data[idx];
      end else begin
        e_err = 1'b1; e_data = '1; e_lat = TO + 2;
      end
    end
    if (e_err && exp_ecnt != 16'hFFFF) exp_ecnt++;
    exp_q.push_back({e_err, e_data});
    lat_q.push_back(e_lat);

    m_read_enable  = rd;
    m_write_enable = wr;
    m_byte_enable  = be;
    m_address      = addr;
    m_write_data   = wdata;
    n = 0; strobes = 0; sel_seen = '0; done = 0;
    while (!done && n < 60) begin
      @(posedge clock); #1;
      n++;
      if (n == 1 && hit) begin
        check({tag, ".sel"},   s_select, 64'(NS'(1) << idx));
        check({tag, ".saddr"}, s_address, 64'(off[WB-1:0]));
        check({tag, ".sbe"},   s_byte_enable, be);
        check({tag, ".srd"},   s_read_enable, rd & ~wr);
        check({tag, ".swr"},   s_write_enable, wr);
        check({tag, ".state"}, dbg_state, 2'd1);
        if (wr) check({tag, ".swdata"}, s_write_data, wdata);
      end
      sel_seen = sel_seen | s_select;
      if (s_read_enable || s_write_enable) strobes++;
      if (m_ready) begin
        m_read_enable  = 1'b0;
        m_write_enable = 1'b0;
        got     = exp_q.pop_front();
        got_lat = lat_q.pop_front();
        check({tag, ".berr"},  m_bus_error, got[DW]);
        check({tag, ".rdata"}, m_read_data, got[DW-1:0]);
        check({tag, ".lat"},   n, got_lat);
        check({tag, ".ecnt"},  error_count, exp_ecnt);
        check({tag, ".strb"},  strobes, hit ? got_lat - 1 : 0);
        if (!hit) check({tag, ".nosel"}, sel_seen, 0);
        done = 1;
      end
    end
    if (!done) begin
      m_read_enable  = 1'b0;
      m_write_enable = 1'b0;
      check({tag, ".no_ready"}, 0, 1);
    end
    @(posedge clock); #1;
    check({tag, ".rdy_low"},  m_ready, 0);
    check({tag, ".berr_low"}, m_bus_error, 0);
    check({tag, ".hold"},     m_read_data, e_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_errors = 0; exp_ecnt = '0; acc_n = 0;
    s_ready = '0;
    reset = 1'b1;
    m_read_enable = 0; m_write_enable = 0; m_byte_enable = '0;
    m_address = '0; m_write_data = '0;
    for (int i = 0; i < NS; i++) begin
      slv_data[i] = $urandom();
      wait_cfg[i] = 0;
    end
    slv_data[1] = 32'hCAFE_F00D;
    repeat (2) @(posedge clock);
    #1;
    check("rst.ready", m_ready, 0);
    check("rst.berr",  m_bus_error, 0);
    check("rst.rdata", m_read_data, 0);
    check("rst.sel",   s_select, 0);
    check("rst.strb",  {s_read_enable, s_write_enable}, 0);
    check("rst.ecnt",  error_count, 0);
    check("rst.state", dbg_state, 0);
    reset = 1'b0;

    run_txn(1, 0, 4'hF, 32'hFF20_0104, 32'h0, 0, "t1_read");
    run_txn(0, 1, 4'b0011, 32'hFF20_0300, 32'h0000_1234, 5, "t2_write_wait");
    run_txn(1, 0, 4'hF, 32'hFF20_0800, 32'h0, 0, "t3_miss_high");
    run_txn(1, 0, 4'hF, 32'hFF1F_FFFC, 32'h0, 0, "t3_miss_low");
    run_txn(1, 0, 4'hF, 32'hFF20_0200, 32'h0, 1000, "t4_timeout");
    run_txn(1, 1, 4'hF, 32'hFF20_0010, 32'hA5A5_5A5A, 2, "t5_rdwr");
    run_txn(1, 0, 4'hF, 32'hFF20_0480, 32'h0, TO, "b_last_wait");
    run_txn(1, 0, 4'hF, 32'hFF20_0580, 32'h0, TO + 1, "b_first_to");
    run_txn(1, 0, 4'hF, 32'hFF20_07FC, 32'h0, 1, "b_top_slave");

    for (int k = 0; k < 8; k++) begin
      logic [31:0] a;
      bit          w;
      a = BASE + {21'h0, 3'($urandom_range(0, NS - 1)), 8'($urandom_range(0, 255))};
      w = 1'($urandom_range(0, 1));
      run_txn(!w, w, 4'($urandom_range(1, 15)), a, $urandom(), $urandom_range(0, 4), "rnd");
    end

    // Reset in the middle of an access
    wait_cfg[2]    = 1000;
    m_read_enable  = 1'b1;
    m_address      = 32'hFF20_0220;
    repeat (3) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("t6.sel",   s_select, 0);
    check("t6.srd",   s_read_enable, 0);
    check("t6.ready", m_ready, 0);
    check("t6.rdata", m_read_data, 0);
    check("t6.ecnt",  error_count, 0);
    check("t6.state", dbg_state, 0);
    exp_ecnt = '0;
    m_read_enable = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    begin
      int pulses;
      pulses = 0;
      repeat (20) begin
        @(posedge clock); #1;
        if (m_ready) pulses++;
      end
      check("t6.no_pulse", pulses, 0);
    end
    run_txn(1, 0, 4'hF, 32'hFF20_0104, 32'h0, 0, "t6_after");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
